// File: rtl/namuru_pkg.sv
// Shared definitions for the namuru tracking core: FSM state type and default
// channel-array dimensions.
package namuru_pkg;

  localparam int DEF_NUM_CHAN = 12;
  localparam int DEF_SEQ_W    = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } accum_irq_state_t;

endpackage

// File: rtl/namuru_accum_irq_ctrl_if.sv
// CPU-side register interface of the accumulation-interrupt controller:
// the CPU (master) drives mask/ack and reads the latched window status.
interface namuru_accum_irq_ctrl_if
  import namuru_pkg::*;
#(
  parameter int NUM_CHAN = DEF_NUM_CHAN,
  parameter int SEQ_W    = DEF_SEQ_W
) ();

  logic [NUM_CHAN-1:0] irq_mask;
  logic                ack;
  logic                irq;
  logic [NUM_CHAN-1:0] status;
  logic [NUM_CHAN-1:0] overrun;
  logic                tic_flag;
  logic                accum_missed;
  logic [SEQ_W-1:0]    seq;

  modport master (
    output irq_mask, ack,
    input  irq, status, overrun, tic_flag, accum_missed, seq
  );

  modport slave (
    input  irq_mask, ack,
    output irq, status, overrun, tic_flag, accum_missed, seq
  );

endinterface

// File: rtl/namuru_dump_collector.sv
// Collects per-channel dump pulses and TICs for the open window and presents
// the closing-window view (including same-cycle pulses) at each accum_enable.
module namuru_dump_collector
  import namuru_pkg::*;
#(
  parameter int NUM_CHAN = DEF_NUM_CHAN,
  parameter int SEQ_W    = DEF_SEQ_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                accum_i,
  input  logic                tic_i,
  input  logic [NUM_CHAN-1:0] dump_i,
  output logic [NUM_CHAN-1:0] win_o,
  output logic [NUM_CHAN-1:0] win_ovr_o,
  output logic                win_tic_o,
  output logic [SEQ_W-1:0]    seq_nxt_o
);

  logic [NUM_CHAN-1:0] pend_q, pend_d;
  logic [NUM_CHAN-1:0] ovr_q, ovr_d;
  logic                tic_q, tic_d;
  logic [SEQ_W-1:0]    cnt_q, cnt_d;

  // Same-cycle pulses belong to the window being closed.
  assign win_o     = pend_q | dump_i;
  assign win_ovr_o = ovr_q | (pend_q & dump_i);
  assign win_tic_o = tic_q | tic_i;
  assign seq_nxt_o = cnt_q + SEQ_W'(1);

  always_comb begin
    pend_d = win_o;
    ovr_d  = win_ovr_o;
    tic_d  = win_tic_o;
    cnt_d  = cnt_q;
    if (accum_i) begin
      pend_d = '0;
      ovr_d  = '0;
      tic_d  = 1'b0;
      cnt_d  = seq_nxt_o;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= '0;
      ovr_q  <= '0;
      tic_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      tic_q  <= tic_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/namuru_accum_irq_ctrl.sv
// Accumulation-interrupt controller: snapshots collected dumps at each
// accum_enable, raises irq until the CPU acknowledges, flags missed windows.
module namuru_accum_irq_ctrl
  import namuru_pkg::*;
#(
  parameter int NUM_CHAN = DEF_NUM_CHAN,
  parameter int SEQ_W    = DEF_SEQ_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    accum_enable,
  input  logic                    tic_enable,
  input  logic [NUM_CHAN-1:0]     dump,
  namuru_accum_irq_ctrl_if.slave  cpu
);

  logic [NUM_CHAN-1:0] win, win_ovr;
  logic                win_tic, win_irq;
  logic [SEQ_W-1:0]    seq_nxt;

  accum_irq_state_t    state_q;
  logic                irq_q, tic_flag_q, missed_q;
  logic [NUM_CHAN-1:0] status_q, overrun_q;
  logic [SEQ_W-1:0]    seq_q;

  namuru_dump_collector #(
    .NUM_CHAN (NUM_CHAN),
    .SEQ_W    (SEQ_W)
  ) u_collector (
    .clk       (clk),
    .rstn      (rstn),
    .accum_i   (accum_enable),
    .tic_i     (tic_enable),
    .dump_i    (dump),
    .win_o     (win),
    .win_ovr_o (win_ovr),
    .win_tic_o (win_tic),
    .seq_nxt_o (seq_nxt)
  );

  // Mask is only consulted at snapshot time, so a pending irq is never retracted.
  assign win_irq = ((win & cpu.irq_mask) != '0) || win_tic;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      irq_q      <= 1'b0;
      status_q   <= '0;
      overrun_q  <= '0;
      tic_flag_q <= 1'b0;
      missed_q   <= 1'b0;
      seq_q      <= '0;
    end else begin
      if (accum_enable) seq_q <= seq_nxt;
      unique case (state_q)
        IDLE: begin
          if (accum_enable) begin
            status_q   <= win;
            overrun_q  <= win_ovr;
            tic_flag_q <= win_tic;
            state_q    <= win_irq ? PENDING : IDLE;
            irq_q      <= win_irq;
          end
        end
        PENDING: begin
          if (accum_enable && cpu.ack) begin
            status_q   <= win;
            overrun_q  <= win_ovr;
            tic_flag_q <= win_tic;
            missed_q   <= 1'b0;
            state_q    <= win_irq ? PENDING : IDLE;
            irq_q      <= win_irq;
          end else if (accum_enable) begin
            status_q   <= status_q | win;
            overrun_q  <= overrun_q | win_ovr;
            tic_flag_q <= tic_flag_q | win_tic;
            missed_q   <= 1'b1;
          end else if (cpu.ack) begin
            status_q   <= '0;
            overrun_q  <= '0;
            tic_flag_q <= 1'b0;
            missed_q   <= 1'b0;
            state_q    <= IDLE;
            irq_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cpu.irq          = irq_q;
  assign cpu.status       = status_q;
  assign cpu.overrun      = overrun_q;
  assign cpu.tic_flag     = tic_flag_q;
  assign cpu.accum_missed = missed_q;
  assign cpu.seq          = seq_q;

endmodule

// File: tb/tb_namuru_accum_irq_ctrl.sv
// Scoreboard bench for namuru_accum_irq_ctrl: a behavioural model predicts
// every cycle's outputs, which are queued and compared once the DUT settles.
module tb_namuru_accum_irq_ctrl;

  localparam int NC = 12;
  localparam int SW = 8;

  typedef struct packed {
    logic          irq;
    logic [NC-1:0] status;
    logic [NC-1:0] ovr;
    logic          tic;
    logic          missed;
    logic [SW-1:0] seq;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          accum = 1'b0;
  logic          tic = 1'b0;
  logic [NC-1:0] dump = '0;

  int n_vec = 0;
  int n_err = 0;
  exp_t sbq[$];

  // Reference model state
  logic [NC-1:0] m_pend, m_ovrp, m_status, m_ovr;
  logic          m_ptic, m_tic, m_missed, m_pending;
  logic [SW-1:0] m_cnt, m_seq;

  namuru_accum_irq_ctrl_if #(.NUM_CHAN(NC), .SEQ_W(SW)) cpu_if ();

  namuru_accum_irq_ctrl #(.NUM_CHAN(NC), .SEQ_W(SW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .accum_enable (accum),
    .tic_enable   (tic),
    .dump         (dump),
    .cpu          (cpu_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ovrp = '0; m_ptic = 1'b0; m_cnt = '0;
    m_status = '0; m_ovr = '0; m_tic = 1'b0; m_missed = 1'b0;
    m_pending = 1'b0; m_seq = '0;
  endtask

  task automatic push_expected();
    exp_t e;
    e.irq = m_pending; e.status = m_status; e.ovr = m_ovr;
    e.tic = m_tic; e.missed = m_missed; e.seq = m_seq;
    sbq.push_back(e);
  endtask

  task automatic model_step(input logic a, input logic t, input logic [NC-1:0] d,
                            input logic k, input logic [NC-1:0] mask);
    logic [NC-1:0] w, o;
    logic          tt, go;
    w  = m_pend | d;
    o  = m_ovrp | (m_pend & d);
    tt = m_ptic | t;
    go = ((w & mask) != '0) || tt;
    if (a) begin
      m_pend = '0; m_ovrp = '0; m_ptic = 1'b0;
      m_cnt  = m_cnt + 1'b1;
      m_seq  = m_cnt;
    end else begin
      m_pend = w; m_ovrp = o; m_ptic = tt;
    end
    if (!m_pending) begin
      if (a) begin
        m_status = w; m_ovr = o; m_tic = tt; m_pending = go;
      end
    end else if (a && k) begin
      m_status = w; m_ovr = o; m_tic = tt; m_missed = 1'b0; m_pending = go;
    end else if (a) begin
      m_status = m_status | w; m_ovr = m_ovr | o; m_tic = m_tic | tt; m_missed = 1'b1;
    end else if (k) begin
      m_status = '0; m_ovr = '0; m_tic = 1'b0; m_missed = 1'b0; m_pending = 1'b0;
    end
  endtask

  task automatic compare_out(input string where);
    exp_t e;
    if (sbq.size() == 0) begin
      check({where, "_sbq_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    check({where, "_irq"},    cpu_if.irq,          e.irq);
    check({where, "_status"}, cpu_if.status,       e.status);
    check({where, "_ovr"},    cpu_if.overrun,      e.ovr);
    check({where, "_tic"},    cpu_if.tic_flag,     e.tic);
    check({where, "_missed"}, cpu_if.accum_missed, e.missed);
    check({where, "_seq"},    cpu_if.seq,          e.seq);
  endtask

  // Drives one cycle of stimulus from a negedge and checks the post-edge outputs.
  task automatic cycle(input logic a, input logic t, input logic [NC-1:0] d, input logic k);
    accum = a; tic = t; dump = d; cpu_if.ack = k;
    model_step(a, t, d, k, cpu_if.irq_mask);
    push_expected();
    @(posedge clk);
    @(negedge clk);
    accum = 1'b0; tic = 1'b0; dump = '0; cpu_if.ack = 1'b0;
    compare_out("cyc");
  endtask

  initial begin
    cpu_if.ack = 1'b0;
    cpu_if.irq_mask = '1;
    model_reset();

    repeat (2) @(negedge clk);
    push_expected();
    compare_out("reset");
    rstn = 1'b1;

    // Two channels dump, then snapshot
    cycle(1'b0, 1'b0, 12'h001, 1'b0);
    cycle(1'b0, 1'b0, 12'h008, 1'b0);
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    check("t1_status", cpu_if.status, 12'h009);
    check("t1_irq", cpu_if.irq, 1'b1);
    check("t1_seq", cpu_if.seq, 8'd1);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    check("t1_ack_irq", cpu_if.irq, 1'b0);
    check("t1_ack_status", cpu_if.status, 12'h000);

    // Double dump in one window
    cycle(1'b0, 1'b0, 12'h004, 1'b0);
    cycle(1'b0, 1'b0, 12'h004, 1'b0);
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    check("t2_overrun", cpu_if.overrun, 12'h004);
    check("t2_status", cpu_if.status, 12'h004);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    check("t2_ack_overrun", cpu_if.overrun, 12'h000);

    // Masked channel updates status silently; TIC alone interrupts
    cpu_if.irq_mask = '0;
    cycle(1'b0, 1'b0, 12'h020, 1'b0);
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    check("t3_status", cpu_if.status, 12'h020);
    check("t3_irq", cpu_if.irq, 1'b0);
    cycle(1'b0, 1'b1, 12'h000, 1'b0);
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    check("t3_tic_irq", cpu_if.irq, 1'b1);
    check("t3_tic_flag", cpu_if.tic_flag, 1'b1);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);

    // Missed window while pending
    cpu_if.irq_mask = '1;
    cycle(1'b0, 1'b0, 12'h010, 1'b0);
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    cycle(1'b0, 1'b0, 12'h002, 1'b0);
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    check("t4_missed", cpu_if.accum_missed, 1'b1);
    check("t4_status", cpu_if.status, 12'h012);

    // Simultaneous ack and accum
    cycle(1'b0, 1'b0, 12'h080, 1'b0);
    cycle(1'b1, 1'b0, 12'h000, 1'b1);
    check("t5_status", cpu_if.status, 12'h080);
    check("t5_missed", cpu_if.accum_missed, 1'b0);
    check("t5_irq", cpu_if.irq, 1'b1);

    // Random traffic with sparse pulses and changing mask
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) cpu_if.irq_mask = NC'($urandom);
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            NC'($urandom) & NC'($urandom) & NC'($urandom),
            ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset while pending
    cpu_if.irq_mask = '1;
    cycle(1'b0, 1'b0, 12'h100, 1'b0);
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    check("t6_pending", cpu_if.irq, 1'b1);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    push_expected();
    compare_out("async_rst");
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 256; i++) cycle(1'b1, 1'b0, 12'h000, 1'b0);
    check("t6_seq_wrap", cpu_if.seq, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
